// File: rtl/dmem_sram.sv
// Synchronous 1W/1R data memory; zeroes every word after reset before serving the LSU.
// Latency: read data and rd_valid_o READ_LAT (1 or 2) cycles after the request; writes land at the edge.
// Backpressure: none; one read and one write are accepted every cycle, and requests during the clear are dropped.
module dmem_sram #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1,
    parameter int RW_FWD   = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dmem_csb_write_i,
    input  logic [3:0]        dmem_wmask_i,
    input  logic [ADDR_W-1:0] dmem_waddr_i,
    input  logic [31:0]       dmem_din_i,
    input  logic              dmem_csb_read_i,
    input  logic [ADDR_W-1:0] dmem_raddr_i,
    output logic [31:0]       dmem_dout_o,
    output logic              rd_valid_o,
    output logic              init_busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       mem_q [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_word;
    logic [31:0]       old_word;
    logic [31:0]       merged_word;
    logic              rd_en;
    logic [31:0]       rd_word;

    logic              stg_vld;
    logic [31:0]       stg_dat;
    logic              out_vld_q, out_vld_d;
    logic [31:0]       out_dat_q, out_dat_d;

    assign old_word = mem_q[dmem_waddr_i];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (dmem_wmask_i[i]) begin
                merged_word[8*i +: 8] = dmem_din_i[8*i +: 8];
            end
        end
    end

    // A same-address collision with forwarding returns the post-write word.
    always_comb begin
        rd_word = mem_q[dmem_raddr_i];
        if (RW_FWD != 0 && !dmem_csb_write_i && dmem_waddr_i == dmem_raddr_i) begin
            rd_word = merged_word;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = dmem_waddr_i;
        wr_word = merged_word;
        rd_en   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_word = 32'h0;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                wr_en = !dmem_csb_write_i;
                rd_en = !dmem_csb_read_i;
            end
            default: state_d = ST_CLEAR;
        endcase
        if (reset_i) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
            wr_en   = 1'b0;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    // The extra stage holds the word as sampled; later writes are not re-forwarded into it.
    if (READ_LAT == 2) begin : g_lat2
        logic        s1_vld_q, s1_vld_d;
        logic [31:0] s1_dat_q, s1_dat_d;

        always_comb begin
            s1_vld_d = rd_en;
            s1_dat_d = rd_en ? rd_word : s1_dat_q;
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                s1_vld_q <= 1'b0;
                s1_dat_q <= 32'h0;
            end else begin
                s1_vld_q <= s1_vld_d;
                s1_dat_q <= s1_dat_d;
            end
        end

        assign stg_vld = s1_vld_q;
        assign stg_dat = s1_dat_q;
    end else begin : g_lat1
        assign stg_vld = rd_en;
        assign stg_dat = rd_word;
    end

    always_comb begin
        out_vld_d = stg_vld;
        out_dat_d = stg_vld ? stg_dat : out_dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_vld_q <= 1'b0;
            out_dat_q <= 32'h0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign dmem_dout_o = out_dat_q;
    assign rd_valid_o  = out_vld_q;
    assign init_busy_o = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_sram.sv
// Directed bench: dut0 uses READ_LAT=1/RW_FWD=1, dut1 uses READ_LAT=2/RW_FWD=0, both on shared stimulus.
module tb_dmem_sram;

    logic        clk = 1'b0;
    logic        reset;
    logic        csb_w, csb_r;
    logic [3:0]  wmask;
    logic [7:0]  waddr, raddr;
    logic [31:0] din;
    logic [31:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    dmem_sram #(.ADDR_W(8), .READ_LAT(1), .RW_FWD(1)) dut0 (
        .clk_i(clk), .reset_i(reset),
        .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask), .dmem_waddr_i(waddr), .dmem_din_i(din),
        .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
        .dmem_dout_o(dout0), .rd_valid_o(vld0), .init_busy_o(busy0)
    );

    dmem_sram #(.ADDR_W(8), .READ_LAT(2), .RW_FWD(0)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask), .dmem_waddr_i(waddr), .dmem_din_i(din),
        .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
        .dmem_dout_o(dout1), .rd_valid_o(vld1), .init_busy_o(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        csb_w = 1'b1; csb_r = 1'b1; wmask = 4'h0; waddr = 8'h0; raddr = 8'h0; din = 32'h0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        csb_w = 1'b0; waddr = a; din = d; wmask = m;
        step();
        csb_w = 1'b1;
    endtask

    // Steps until dut0 leaves CLEAR; reports cycle count and whether any read-valid appeared.
    task automatic wait_clear(output int n, output logic saw_vld);
        n = 0;
        saw_vld = 1'b0;
        while (busy0 && n < 1000) begin
            step();
            n++;
            if (vld0 || vld1) saw_vld = 1'b1;
        end
    endtask

    task automatic test_reset();
        int   n;
        logic sv;
        idle_inputs();
        reset = 1'b1;
        step(); step();
        n_total++; if (dout0 !== 32'h0) $display("FAIL rst_dout0 got %h exp %h", dout0, 32'h0); else n_pass++;
        n_total++; if (dout1 !== 32'h0) $display("FAIL rst_dout1 got %h exp %h", dout1, 32'h0); else n_pass++;
        n_total++; if (vld0 !== 1'b0 || vld1 !== 1'b0) $display("FAIL rst_vld got %b%b exp 00", vld0, vld1); else n_pass++;
        n_total++; if (busy0 !== 1'b1 || busy1 !== 1'b1) $display("FAIL rst_busy got %b%b exp 11", busy0, busy1); else n_pass++;
        reset = 1'b0;
        wait_clear(n, sv);
        n_total++; if (n !== 256) $display("FAIL clear_len got %0d exp 256", n); else n_pass++;
        n_total++; if (busy1 !== 1'b0) $display("FAIL clear_busy1 got %b exp 0", busy1); else n_pass++;
        n_total++; if (sv !== 1'b0) $display("FAIL clear_vld got %b exp 0", sv); else n_pass++;
    endtask

    task automatic test_read_all();
        for (int a = 0; a < 256; a++) begin
            raddr = 8'(a); csb_r = 1'b0;
            step();
            csb_r = 1'b1;
            n_total++; if (vld0 !== 1'b1 || dout0 !== 32'h0) $display("FAIL rdall0 a=%0d got %b/%h exp 1/0", a, vld0, dout0); else n_pass++;
            n_total++; if (vld1 !== 1'b0) $display("FAIL rdall1_early a=%0d got %b exp 0", a, vld1); else n_pass++;
            step();
            n_total++; if (vld1 !== 1'b1 || dout1 !== 32'h0) $display("FAIL rdall1 a=%0d got %b/%h exp 1/0", a, vld1, dout1); else n_pass++;
            n_total++; if (vld0 !== 1'b0) $display("FAIL rdall0_pulse a=%0d got %b exp 0", a, vld0); else n_pass++;
        end
    endtask

    task automatic test_write_mask();
        do_write(8'd5, 32'hDEADBEEF, 4'hF);
        do_write(8'd5, 32'h000000AA, 4'b0001);
        do_write(8'd5, 32'hFFFFFFFF, 4'b0000);
        raddr = 8'd5; csb_r = 1'b0;
        step();
        csb_r = 1'b1;
        n_total++; if (vld0 !== 1'b1 || dout0 !== 32'hDEADBEAA) $display("FAIL wmask0 got %b/%h exp 1/deadbeaa", vld0, dout0); else n_pass++;
        n_total++; if (vld1 !== 1'b0) $display("FAIL wmask1_early got %b exp 0", vld1); else n_pass++;
        step();
        n_total++; if (vld1 !== 1'b1 || dout1 !== 32'hDEADBEAA) $display("FAIL wmask1 got %b/%h exp 1/deadbeaa", vld1, dout1); else n_pass++;
        n_total++; if (vld0 !== 1'b0 || dout0 !== 32'hDEADBEAA) $display("FAIL hold0 got %b/%h exp 0/deadbeaa", vld0, dout0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp0, exp1;
        do_write(8'd3, 32'h3, 4'hF);
        do_write(8'd4, 32'h4, 4'hF);
        do_write(8'd5, 32'h5, 4'hF);
        for (int i = 0; i < 3; i++) begin
            raddr = 8'(3 + i); csb_r = 1'b0;
            step();
            exp0 = 32'(3 + i);
            exp1 = 32'(2 + i);
            n_total++; if (vld0 !== 1'b1 || dout0 !== exp0) $display("FAIL b2b0 i=%0d got %b/%h exp 1/%h", i, vld0, dout0, exp0); else n_pass++;
            if (i > 0) begin
                n_total++; if (vld1 !== 1'b1 || dout1 !== exp1) $display("FAIL b2b1 i=%0d got %b/%h exp 1/%h", i, vld1, dout1, exp1); else n_pass++;
            end else begin
                n_total++; if (vld1 !== 1'b0) $display("FAIL b2b1_first got %b exp 0", vld1); else n_pass++;
            end
        end
        csb_r = 1'b1;
        step();
        n_total++; if (vld0 !== 1'b0) $display("FAIL b2b0_end got %b exp 0", vld0); else n_pass++;
        n_total++; if (vld1 !== 1'b1 || dout1 !== 32'h5) $display("FAIL b2b1_last got %b/%h exp 1/5", vld1, dout1); else n_pass++;
        step();
        n_total++; if (vld1 !== 1'b0) $display("FAIL b2b1_end got %b exp 0", vld1); else n_pass++;
    endtask

    task automatic test_collision();
        do_write(8'd7, 32'h11223344, 4'hF);
        csb_w = 1'b0; waddr = 8'd7; din = 32'hAABBCCDD; wmask = 4'b1100;
        csb_r = 1'b0; raddr = 8'd7;
        step();
        idle_inputs();
        n_total++; if (dout0 !== 32'hAABB3344) $display("FAIL coll_fwd got %h exp aabb3344", dout0); else n_pass++;
        step();
        n_total++; if (vld1 !== 1'b1 || dout1 !== 32'h11223344) $display("FAIL coll_old got %b/%h exp 1/11223344", vld1, dout1); else n_pass++;
        raddr = 8'd7; csb_r = 1'b0;
        step();
        csb_r = 1'b1;
        n_total++; if (dout0 !== 32'hAABB3344) $display("FAIL coll_after0 got %h exp aabb3344", dout0); else n_pass++;
        step();
        n_total++; if (dout1 !== 32'hAABB3344) $display("FAIL coll_after1 got %h exp aabb3344", dout1); else n_pass++;
        // Different addresses in the same cycle are independent.
        csb_w = 1'b0; waddr = 8'd8; din = 32'hCAFEF00D; wmask = 4'hF;
        csb_r = 1'b0; raddr = 8'd5;
        step();
        idle_inputs();
        n_total++; if (dout0 !== 32'h5) $display("FAIL diff_rd0 got %h exp 5", dout0); else n_pass++;
        step();
        n_total++; if (dout1 !== 32'h5) $display("FAIL diff_rd1 got %h exp 5", dout1); else n_pass++;
        raddr = 8'd8; csb_r = 1'b0;
        step();
        csb_r = 1'b1;
        n_total++; if (dout0 !== 32'hCAFEF00D) $display("FAIL diff_wr got %h exp cafef00d", dout0); else n_pass++;
        step();
    endtask

    task automatic test_reset_midflight();
        int   n;
        logic sv;
        do_write(8'd9, 32'h12345678, 4'hF);
        raddr = 8'd9; csb_r = 1'b0;
        step();
        csb_r = 1'b1;
        n_total++; if (vld0 !== 1'b1 || dout0 !== 32'h12345678) $display("FAIL pre_rst0 got %b/%h exp 1/12345678", vld0, dout0); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++; if (vld1 !== 1'b0 || vld0 !== 1'b0) $display("FAIL flush got %b%b exp 00", vld0, vld1); else n_pass++;
        n_total++; if (busy0 !== 1'b1 || busy1 !== 1'b1) $display("FAIL flush_busy got %b%b exp 11", busy0, busy1); else n_pass++;
        sv = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (vld0 || vld1) sv = 1'b1;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++; if (busy0 !== 1'b1) $display("FAIL midclr_busy got %b exp 1", busy0); else n_pass++;
        wait_clear(n, sv);
        n_total++; if (n !== 256) $display("FAIL midclr_len got %0d exp 256", n); else n_pass++;
        n_total++; if (sv !== 1'b0) $display("FAIL midclr_vld got %b exp 0", sv); else n_pass++;
        raddr = 8'd9; csb_r = 1'b0;
        step();
        csb_r = 1'b1;
        n_total++; if (vld0 !== 1'b1 || dout0 !== 32'h0) $display("FAIL cleared9_0 got %b/%h exp 1/0", vld0, dout0); else n_pass++;
        step();
        n_total++; if (vld1 !== 1'b1 || dout1 !== 32'h0) $display("FAIL cleared9_1 got %b/%h exp 1/0", vld1, dout1); else n_pass++;
    endtask

    task automatic test_clear_requests();
        int   n;
        logic sv;
        reset = 1'b1;
        step();
        reset = 1'b0;
        csb_w = 1'b0; waddr = 8'd2; din = 32'hFFFFFFFF; wmask = 4'hF;
        csb_r = 1'b0; raddr = 8'd2;
        wait_clear(n, sv);
        idle_inputs();
        n_total++; if (n !== 256) $display("FAIL clrreq_len got %0d exp 256", n); else n_pass++;
        n_total++; if (sv !== 1'b0) $display("FAIL clrreq_vld got %b exp 0", sv); else n_pass++;
        raddr = 8'd2; csb_r = 1'b0;
        step();
        csb_r = 1'b1;
        n_total++; if (vld0 !== 1'b1 || dout0 !== 32'h0) $display("FAIL clrreq_rd0 got %b/%h exp 1/0", vld0, dout0); else n_pass++;
        step();
        n_total++; if (vld1 !== 1'b1 || dout1 !== 32'h0) $display("FAIL clrreq_rd1 got %b/%h exp 1/0", vld1, dout1); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_read_all();
        test_write_mask();
        test_back_to_back();
        test_collision();
        test_reset_midflight();
        test_clear_requests();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
